// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures decoded fields and operands from decode and
// presents them, registered, to execute. Supports stall (hold), flush (bubble),
// HALT freezing and a saturating stalled-cycle counter.
module id_ex_pipe #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [4:0]          id_aluOp,
    input  logic [1:0]          id_funct,
    input  logic [WIDTH-1:0]    id_rs_data,
    input  logic [WIDTH-1:0]    id_rt_data,
    input  logic [WIDTH-1:0]    id_imm,
    input  logic                id_aluSrc,
    input  logic [REG_BITS-1:0] id_wr_reg,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic [WIDTH-1:0]    id_pc_inc,
    output logic                ex_valid,
    output logic [4:0]          ex_aluOp,
    output logic [1:0]          ex_funct,
    output logic [WIDTH-1:0]    ex_rs_data,
    output logic [WIDTH-1:0]    ex_rt_data,
    output logic [WIDTH-1:0]    ex_imm,
    output logic                ex_aluSrc,
    output logic [REG_BITS-1:0] ex_wr_reg,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic [WIDTH-1:0]    ex_pc_inc,
    output logic                halted,
    output logic [15:0]         stall_cnt
);

    localparam logic [4:0]  OP_HALT  = 5'b00000;
    localparam logic [4:0]  OP_NOP   = 5'b00001;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    logic                valid_s;
    logic [4:0]          aluop_s;
    logic [1:0]          funct_s;
    logic [WIDTH-1:0]    rs_data_s;
    logic [WIDTH-1:0]    rt_data_s;
    logic [WIDTH-1:0]    imm_s;
    logic                alusrc_s;
    logic [REG_BITS-1:0] wr_reg_s;
    logic                reg_write_s;
    logic                mem_read_s;
    logic                mem_write_s;
    logic [WIDTH-1:0]    pc_inc_s;
    logic                halted_s;
    logic [15:0]         stall_cnt_s;
    logic                bubble_s;
    logic                load_s;

    // Next-state selection: halt freeze > flush > stall > load (invalid loads become bubbles).
    always_comb begin
        valid_s     = ex_valid;
        aluop_s     = ex_aluOp;
        funct_s     = ex_funct;
        rs_data_s   = ex_rs_data;
        rt_data_s   = ex_rt_data;
        imm_s       = ex_imm;
        alusrc_s    = ex_aluSrc;
        wr_reg_s    = ex_wr_reg;
        reg_write_s = ex_reg_write;
        mem_read_s  = ex_mem_read;
        mem_write_s = ex_mem_write;
        pc_inc_s    = ex_pc_inc;
        halted_s    = halted;
        stall_cnt_s = stall_cnt;
        bubble_s    = 1'b0;
        load_s      = 1'b0;

        if (halted) begin
            bubble_s = 1'b0;
        end else if (flush) begin
            bubble_s = 1'b1;
        end else if (stall) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt_s = stall_cnt + 16'd1;
            end else begin
                stall_cnt_s = stall_cnt;
            end
        end else if (id_valid) begin
            load_s = 1'b1;
        end else begin
            bubble_s = 1'b1;
        end

        if (bubble_s) begin
            valid_s     = 1'b0;
            aluop_s     = OP_NOP;
            funct_s     = 2'b00;
            rs_data_s   = {WIDTH{1'b0}};
            rt_data_s   = {WIDTH{1'b0}};
            imm_s       = {WIDTH{1'b0}};
            alusrc_s    = 1'b0;
            wr_reg_s    = {REG_BITS{1'b0}};
            reg_write_s = 1'b0;
            mem_read_s  = 1'b0;
            mem_write_s = 1'b0;
            pc_inc_s    = {WIDTH{1'b0}};
        end else if (load_s) begin
            valid_s     = 1'b1;
            aluop_s     = id_aluOp;
            funct_s     = id_funct;
            rs_data_s   = id_rs_data;
            rt_data_s   = id_rt_data;
            imm_s       = id_imm;
            alusrc_s    = id_aluSrc;
            wr_reg_s    = id_wr_reg;
            reg_write_s = id_reg_write;
            mem_read_s  = id_mem_read;
            mem_write_s = id_mem_write;
            pc_inc_s    = id_pc_inc;
            halted_s    = (id_aluOp == OP_HALT);
        end else begin
            load_s = 1'b0;
        end
    end

    // Pipeline state registers with asynchronous reset to the NOP bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_aluOp     <= OP_NOP;
            ex_funct     <= 2'b00;
            ex_rs_data   <= {WIDTH{1'b0}};
            ex_rt_data   <= {WIDTH{1'b0}};
            ex_imm       <= {WIDTH{1'b0}};
            ex_aluSrc    <= 1'b0;
            ex_wr_reg    <= {REG_BITS{1'b0}};
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_pc_inc    <= {WIDTH{1'b0}};
            halted       <= 1'b0;
            stall_cnt    <= 16'd0;
        end else begin
            ex_valid     <= valid_s;
            ex_aluOp     <= aluop_s;
            ex_funct     <= funct_s;
            ex_rs_data   <= rs_data_s;
            ex_rt_data   <= rt_data_s;
            ex_imm       <= imm_s;
            ex_aluSrc    <= alusrc_s;
            ex_wr_reg    <= wr_reg_s;
            ex_reg_write <= reg_write_s;
            ex_mem_read  <= mem_read_s;
            ex_mem_write <= mem_write_s;
            ex_pc_inc    <= pc_inc_s;
            halted       <= halted_s;
            stall_cnt    <= stall_cnt_s;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized traffic,
// compared against a transaction-level reference model.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid;
        logic [4:0]  aluop;
        logic [1:0]  funct;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] imm;
        logic        alusrc;
        logic [2:0]  wr_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [15:0] pc;
    } stage_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_aluOp = 5'd0;
    logic [1:0]  id_funct = 2'd0;
    logic [15:0] id_rs_data = 16'd0;
    logic [15:0] id_rt_data = 16'd0;
    logic [15:0] id_imm = 16'd0;
    logic        id_aluSrc = 1'b0;
    logic [2:0]  id_wr_reg = 3'd0;
    logic        id_reg_write = 1'b0;
    logic        id_mem_read = 1'b0;
    logic        id_mem_write = 1'b0;
    logic [15:0] id_pc_inc = 16'd0;

    logic        ex_valid;
    logic [4:0]  ex_aluOp;
    logic [1:0]  ex_funct;
    logic [15:0] ex_rs_data;
    logic [15:0] ex_rt_data;
    logic [15:0] ex_imm;
    logic        ex_aluSrc;
    logic [2:0]  ex_wr_reg;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [15:0] ex_pc_inc;
    logic        halted;
    logic [15:0] stall_cnt;

    id_ex_pipe #(.WIDTH(16), .REG_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluOp(id_aluOp), .id_funct(id_funct),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_aluSrc(id_aluSrc), .id_wr_reg(id_wr_reg), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_pc_inc(id_pc_inc),
        .ex_valid(ex_valid), .ex_aluOp(ex_aluOp), .ex_funct(ex_funct),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_aluSrc(ex_aluSrc), .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc_inc(ex_pc_inc),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (transaction level).
    stage_t m_ex;
    bit     m_halted;
    int     m_cnt;

    function automatic stage_t bubble();
        stage_t b;
        b = '0;
        b.aluop = 5'b00001;
        return b;
    endfunction

    function automatic stage_t id_now();
        stage_t s;
        s = {id_valid, id_aluOp, id_funct, id_rs_data, id_rt_data, id_imm,
             id_aluSrc, id_wr_reg, id_reg_write, id_mem_read, id_mem_write, id_pc_inc};
        return s;
    endfunction

    function automatic stage_t ex_now();
        stage_t s;
        s = {ex_valid, ex_aluOp, ex_funct, ex_rs_data, ex_rt_data, ex_imm,
             ex_aluSrc, ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_pc_inc};
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex     = bubble();
        m_halted = 1'b0;
        m_cnt    = 0;
    endtask

    // Apply the stage rules for one rising edge using the currently driven inputs.
    task automatic model_edge();
        if (m_halted) begin
            return;
        end
        if (flush) begin
            m_ex = bubble();
        end else if (stall) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else if (!id_valid) begin
            m_ex = bubble();
        end else begin
            m_ex = id_now();
            if (id_aluOp == 5'b00000) m_halted = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ex"}, 128'(ex_now()), 128'(m_ex));
        check({tag, ".halted"}, 128'(halted), 128'(m_halted));
        check({tag, ".cnt"}, 128'(stall_cnt), 128'(m_cnt));
    endtask

    task automatic rand_id(input bit allow_halt);
        id_valid     = ($urandom_range(0, 3) != 0);
        id_aluOp     = allow_halt ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
        id_funct     = 2'($urandom);
        id_rs_data   = 16'($urandom);
        id_rt_data   = 16'($urandom);
        id_imm       = 16'($urandom);
        id_aluSrc    = 1'($urandom);
        id_wr_reg    = 3'($urandom);
        id_reg_write = 1'($urandom);
        id_mem_read  = 1'($urandom);
        id_mem_write = 1'($urandom);
        id_pc_inc    = 16'($urandom);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] frozen_cnt;
        model_reset();
        stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.aluop", 128'(ex_aluOp), 128'(5'b00001));
        @(negedge clk);
        rst_n = 1'b1;

        // Normal load.
        rand_id(1'b0);
        id_valid = 1'b1; id_aluOp = 5'b11011; id_funct = 2'b01;
        id_rs_data = 16'h1234; id_rt_data = 16'h0F0F;
        step();
        check_all("load");
        check("load.rs", 128'(ex_rs_data), 128'(16'h1234));
        check("load.valid", 128'(ex_valid), 128'(1'b1));
        check("load.cnt0", 128'(stall_cnt), 128'(16'd0));

        // Stall then release.
        rand_id(1'b0);
        id_valid = 1'b1; id_aluOp = 5'b01000;
        step();
        check_all("addi");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id(1'b0);
            step();
            check_all("stall");
            check("stall.aluop", 128'(ex_aluOp), 128'(5'b01000));
        end
        stall = 1'b0;
        rand_id(1'b0);
        id_valid = 1'b1;
        step();
        check_all("release");
        check("release.cnt", 128'(stall_cnt), 128'(16'd3));

        // Flush over stall.
        stall = 1'b1; flush = 1'b1;
        rand_id(1'b0);
        id_valid = 1'b1; id_reg_write = 1'b1; id_mem_write = 1'b1;
        step();
        check_all("flushstall");
        check("flushstall.bub", 128'({ex_valid, ex_aluOp, ex_reg_write, ex_mem_write}),
              128'({1'b0, 5'b00001, 1'b0, 1'b0}));
        check("flushstall.cnt", 128'(stall_cnt), 128'(16'd3));
        stall = 1'b0; flush = 1'b0;

        // Back-to-back flushes.
        flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_id(1'b0);
            step();
            check_all("flush2");
        end
        flush = 1'b0;

        // Randomized traffic (no HALT).
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rand_id(1'b0);
            step();
            check_all("rand");
        end

        // Counter saturation.
        flush = 1'b0; stall = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            rand_id(1'b0);
            step();
        end
        check_all("sat");
        check("sat.cnt", 128'(stall_cnt), 128'(16'hFFFF));
        stall = 1'b0;
        rand_id(1'b0);
        step();
        stall = 1'b1;
        step();
        step();
        check_all("sat.hold");
        check("sat.hold.cnt", 128'(stall_cnt), 128'(16'hFFFF));
        stall = 1'b0;

        // Fresh state, preload 0x42 stalls, then HALT freeze.
        do_reset();
        stall = 1'b1;
        repeat (16'h42) begin
            rand_id(1'b0);
            step();
        end
        check("pre.cnt", 128'(stall_cnt), 128'(16'h0042));
        stall = 1'b0;
        rand_id(1'b0);
        id_valid = 1'b1; id_aluOp = 5'b00000;
        step();
        check_all("halt");
        check("halt.flag", 128'(halted), 128'(1'b1));
        frozen_cnt = stall_cnt;
        for (int i = 0; i < 5; i++) begin
            stall = 1'($urandom); flush = 1'($urandom);
            rand_id(1'b1);
            step();
            check_all("frozen");
            check("frozen.aluop", 128'({halted, ex_aluOp, ex_valid}), 128'({1'b1, 5'b00000, 1'b1}));
            check("frozen.cnt", 128'(stall_cnt), 128'(frozen_cnt));
        end
        stall = 1'b0; flush = 1'b0;

        // Asynchronous reset mid-cycle while halted.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async.halted", 128'(halted), 128'(1'b0));
        check("async.cnt", 128'(stall_cnt), 128'(16'd0));
        check("async.aluop", 128'(ex_aluOp), 128'(5'b00001));
        check_all("async");
        #1 rst_n = 1'b1;

        // HALT arriving with stall or flush must not freeze.
        rand_id(1'b0);
        id_valid = 1'b1; id_aluOp = 5'b00000; stall = 1'b1;
        step();
        check_all("haltstall");
        stall = 1'b0; flush = 1'b1;
        step();
        check_all("haltflush");
        flush = 1'b0;

        // First edge after reset release loads normally.
        do_reset();
        rand_id(1'b0);
        id_valid = 1'b1;
        step();
        check_all("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register for the 16-bit five-stage processor. It captures decoded instruction fields and operands from decode and presents them, registered, to the execute stage. In execute, `ex_aluOp`/`ex_funct` feed the ALU control decoder and the operands feed the ALU. It handles stall (hold), flush (bubble insertion), halt freezing and a saturating stall-cycle counter.

## Interface
Parameters:
- `WIDTH`, 16, datapath width of operands, immediate and PC.
- `REG_BITS`, 3, register-specifier width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit request to hold current contents.
- `flush`  in  1  branch/jump resolution request to replace contents with a bubble.
- `id_valid`  in  1  decode presents a real instruction.
- `id_aluOp`  in  5  ALU opcode class from decode.
- `id_funct`  in  2  function bits for R-format ops.
- `id_rs_data`  in  WIDTH  operand A.
- `id_rt_data`  in  WIDTH  operand B.
- `id_imm`  in  WIDTH  sign/zero-extended immediate.
- `id_aluSrc`  in  1  select immediate as ALU B.
- `id_wr_reg`  in  REG_BITS  destination register.
- `id_reg_write`  in  1  register write enable.
- `id_mem_read`  in  1  load.
- `id_mem_write`  in  1  store.
- `id_pc_inc`  in  WIDTH  PC+2 of the instruction.
- `ex_*`  out  (same widths)  registered copies of every `id_*` input above, including `ex_valid`.
- `halted`  out  1  a valid HALT has reached execute; the stage is frozen.
- `stall_cnt`  out  16  saturating count of stalled cycles.

## Operation
- Reset (`rst_n`=0, asynchronous) sets all outputs to these values:
  - `ex_valid`=0, `ex_aluOp`=5'b00001 (NOP), `halted`=0, `stall_cnt`=0.
  - Every other `ex_*` output = 0.
- Bubble is defined as `ex_valid`=0, `ex_aluOp`=5'b00001, with all control bits, data, `ex_wr_reg` and `ex_pc_inc` = 0.
- Per-edge priority, highest first:
  1. Halted state: if `halted`=1, all registers hold and `stall`/`flush`/`id_*` are ignored. Only reset clears it.
  2. Flush: if `flush`=1, load a bubble. This applies regardless of `stall`.
  3. Stall: if `stall`=1, all `ex_*` hold.
  4. Otherwise, load all `id_*` into `ex_*`.
- Invalid input: when a load occurs with `id_valid`=0, a bubble is loaded, not the raw fields.
- Halt detection:
  - On a load where `id_valid`=1 and `id_aluOp`=5'b00000, `halted` sets on the same edge.
  - `ex_*` then shows the HALT with `ex_valid`=1.
  - A HALT arriving with `flush`=1 or `stall`=1 does not set `halted`.
- Stall counter:
  - Increments on each edge where `stall`=1, `flush`=0 and `halted`=0.
  - Saturates at 16'hFFFF and does not wrap.
  - Holds otherwise.
- No combinational path from any input to any output.

## Timing
- Latency is one cycle: `id_*` sampled at edge N appears on `ex_*` after edge N.
- Stall holds for exactly as many edges as `stall` is high. Release loads on the first edge with `stall`=0.
- Flush is single-edge: one flush cycle produces exactly one bubble. Back-to-back flushes produce consecutive bubbles.
- `halted` rises coincident with the HALT appearing on `ex_*` and stays high until `rst_n` falls.
- Asynchronous reset mid-stall or mid-halt clears immediately, without waiting for a clock edge.
- The first edge after reset release with no stall/flush performs a normal load.

## Test plan
- Normal load: `id_valid`=1, `id_aluOp`=5'b11011, `id_funct`=2'b01, `id_rs_data`=16'h1234, `id_rt_data`=16'h0F0F.
  - After one edge, `ex_*` equal those values and `ex_valid`=1.
  - `stall_cnt` stays 0.
- Stall then release: load ADDI (`id_aluOp`=5'b01000), assert `stall` for 3 cycles while `id_*` change, then deassert.
  - `ex_*` hold the ADDI for 3 cycles and load the new values on the next edge.
  - `stall_cnt`=3.
- Flush over stall: `stall`=1 and `flush`=1 on the same edge with a valid `id_*`.
  - Result is a bubble: `ex_valid`=0, `ex_aluOp`=5'b00001, `ex_reg_write`=0, `ex_mem_write`=0.
  - `stall_cnt` is unchanged.
- Halt freeze: load valid `id_aluOp`=5'b00000, then drive `flush`, `stall` and new `id_*` for 5 cycles.
  - `halted`=1 and `ex_aluOp`=5'b00000 throughout.
  - Outputs are unchanged and `stall_cnt` is frozen.
- Counter saturation: preload by holding `stall`=1 for 65537 cycles.
  - `stall_cnt`=16'hFFFF and stays there.
- Async reset: pulse `rst_n` low mid-cycle while halted with `stall_cnt`=16'h0042.
  - Outputs immediately return to reset values (`halted`=0, `stall_cnt`=0, `ex_aluOp`=5'b00001) before the next edge.
